// File: rtl/test_sequencer.sv
// Purpose: run controller that sequences one test campaign: reset, enable, drain, freeze, capture results.
// Latency: accepted i_start to first o_enable = RESET_CYCLES+1 cycles; all outputs registered.
// Backpressure: none; i_start is ignored while busy, and i_abort (level) forces IDLE. Optional early stop: SEQ_EARLY_STOP_EN.
module test_sequencer #(
  parameter int WIDTH_LEN    = 32,
  parameter int RESET_CYCLES = 4,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [WIDTH_LEN-1:0] i_run_len,
`ifdef SEQ_EARLY_STOP_EN
  input  logic [31:0]          i_stop_limit,
  output logic                 o_early,
`endif
  input  logic [31:0]          i_data_ctr,
  input  logic [31:0]          i_event_ctr,
  output logic                 o_tb_reset,
  output logic                 o_enable,
  output logic                 o_freeze,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [31:0]          o_res_data,
  output logic [31:0]          o_res_events,
  output logic [2:0]           o_state
);

  // Counter must hold both the run length and the 8-bit reset/drain loads.
  localparam int CW = (WIDTH_LEN > 8) ? WIDTH_LEN : 8;
  localparam logic [CW-1:0] RST_LOAD   = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_FRZ   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               state_q, state_nxt;
  logic [CW-1:0]        cnt_q, cnt_nxt;
  logic [WIDTH_LEN-1:0] run_len_q, run_len_nxt;
  logic                 accept;
  logic                 capture;
  logic                 clr_res;
`ifdef SEQ_EARLY_STOP_EN
  logic [31:0]          stop_q;
  logic                 early_set;
`endif

  assign o_state = state_q;

  // Next-state, counter load/decrement and the capture/clear strobes.
  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    run_len_nxt = run_len_q;
    accept      = 1'b0;
    capture     = 1'b0;
    clr_res     = 1'b0;
`ifdef SEQ_EARLY_STOP_EN
    early_set   = 1'b0;
`endif
    if (i_abort) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      clr_res   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            accept      = 1'b1;
            run_len_nxt = i_run_len;
            cnt_nxt     = RST_LOAD;
            state_nxt   = S_RST;
          end
        end
        S_RST: begin
          if (cnt_q == '0) begin
            // A zero-length run skips RUN entirely so o_enable never pulses.
            if (run_len_q == '0) begin
              cnt_nxt   = DRAIN_LOAD;
              state_nxt = S_DRAIN;
            end else begin
              cnt_nxt   = CW'(run_len_q) - CW'(1);
              state_nxt = S_RUN;
            end
          end else begin
            cnt_nxt = cnt_q - CW'(1);
          end
        end
        S_RUN: begin
`ifdef SEQ_EARLY_STOP_EN
          if ((stop_q != '0) && (i_event_ctr >= stop_q)) begin
            cnt_nxt   = DRAIN_LOAD;
            state_nxt = S_DRAIN;
            early_set = 1'b1;
          end else
`endif
          if (cnt_q == '0) begin
            cnt_nxt   = DRAIN_LOAD;
            state_nxt = S_DRAIN;
          end else begin
            cnt_nxt = cnt_q - CW'(1);
          end
        end
        S_DRAIN: begin
          if (cnt_q == '0) begin
            state_nxt = S_FRZ;
          end else begin
            cnt_nxt = cnt_q - CW'(1);
          end
        end
        S_FRZ: begin
          capture   = 1'b1;
          state_nxt = S_DONE;
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, counter and sampled run parameters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      run_len_q <= '0;
`ifdef SEQ_EARLY_STOP_EN
      stop_q    <= '0;
`endif
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      run_len_q <= run_len_nxt;
`ifdef SEQ_EARLY_STOP_EN
      if (accept) stop_q <= i_stop_limit;
`endif
    end
  end

  // Registered outputs decoded from the next state, plus result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_tb_reset   <= 1'b1;
      o_enable     <= 1'b0;
      o_freeze     <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_pass       <= 1'b0;
      o_res_data   <= '0;
      o_res_events <= '0;
`ifdef SEQ_EARLY_STOP_EN
      o_early      <= 1'b0;
`endif
    end else begin
      o_tb_reset <= (state_nxt == S_IDLE) || (state_nxt == S_RST);
      o_enable   <= (state_nxt == S_RUN);
      o_freeze   <= (state_nxt == S_FRZ) || (state_nxt == S_DONE);
      o_busy     <= (state_nxt == S_RST) || (state_nxt == S_RUN) ||
                    (state_nxt == S_DRAIN) || (state_nxt == S_FRZ);
      o_done     <= (state_nxt == S_DONE);
      // Pass is only meaningful in DONE; any exit from DONE clears it.
      if (capture) o_pass <= (i_event_ctr == '0);
      else         o_pass <= o_pass && (state_nxt == S_DONE);
      // Results survive a restart from DONE until the next capture.
      if (clr_res) begin
        o_res_data   <= '0;
        o_res_events <= '0;
      end else if (capture) begin
        o_res_data   <= i_data_ctr;
        o_res_events <= i_event_ctr;
      end
`ifdef SEQ_EARLY_STOP_EN
      if (clr_res || accept) o_early <= 1'b0;
      else if (early_set)    o_early <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_test_sequencer.sv
// Bench for test_sequencer: table of campaigns with a scoreboard of expected results,
// plus hand-written abort, abort-over-start and async-reset sequences.
// Build with SEQ_EARLY_STOP_EN to add the early-stop campaign.
module tb_test_sequencer;
  localparam int WL = 32;
  localparam int RC = 4;
  localparam int DC = 8;

  logic          clk_dut = 1'b0;
  logic          reset = 1'b0;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  logic [WL-1:0] i_run_len = '0;
  logic [31:0]   i_data_ctr = '0;
  logic [31:0]   i_event_ctr = '0;
`ifdef SEQ_EARLY_STOP_EN
  logic [31:0]   i_stop_limit = '0;
  logic          o_early;
`endif
  logic          o_tb_reset, o_enable, o_freeze, o_busy, o_done, o_pass;
  logic [31:0]   o_res_data, o_res_events;
  logic [2:0]    o_state;

  test_sequencer #(.WIDTH_LEN(WL), .RESET_CYCLES(RC), .DRAIN_CYCLES(DC)) dut (
    .clk(clk_dut), .reset(reset), .i_start(i_start), .i_abort(i_abort),
    .i_run_len(i_run_len),
`ifdef SEQ_EARLY_STOP_EN
    .i_stop_limit(i_stop_limit), .o_early(o_early),
`endif
    .i_data_ctr(i_data_ctr), .i_event_ctr(i_event_ctr),
    .o_tb_reset(o_tb_reset), .o_enable(o_enable), .o_freeze(o_freeze),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
    .o_res_data(o_res_data), .o_res_events(o_res_events), .o_state(o_state)
  );

  always #5 clk_dut = ~clk_dut;

  typedef struct {
    int run_len;
    int inj0;
    int inj1;
    int inj2;
    int restart_at;
    int stop_limit;
    int exp_events;
    bit exp_pass;
    int exp_en;
    bit exp_early;
  } vec_t;

  typedef struct {
    int exp_en;
    int exp_frz;
    int exp_data;
    int exp_events;
    bit exp_pass;
    bit exp_early;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] prev_data = '0;
  vec_t        vecs[6];
  int          nvec;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One campaign: pulse start, play scoreboard counters, pop and compare at DONE.
  task automatic run_vec(input vec_t v);
    exp_t e;
    int   en_cnt, first_en, first_frz, done_t;
    e.exp_en     = v.exp_en;
    e.exp_frz    = RC + v.exp_en + DC + 1;
    e.exp_data   = v.exp_en;
    e.exp_events = v.exp_events;
    e.exp_pass   = v.exp_pass;
    e.exp_early  = v.exp_early;
    sb_q.push_back(e);

    @(posedge clk_dut); #1;
    i_start   = 1'b1;
    i_run_len = WL'(v.run_len);
`ifdef SEQ_EARLY_STOP_EN
    i_stop_limit = v.stop_limit;
`endif
    en_cnt = 0; first_en = 0; first_frz = 0; done_t = 0;
    for (int t = 1; t < 1500 && done_t == 0; t++) begin
      @(posedge clk_dut); #1;
      i_start = 1'b0;
      if (t == 1) begin
        check("start_state_rst", o_state, 1);
        check("start_clears_done", o_done, 0);
        check("results_held", o_res_data, prev_data);
      end
      if (t == RC)     check("tb_reset_held", o_tb_reset, 1);
      if (t == RC + 1) check("tb_reset_release", o_tb_reset, 0);
      if (o_tb_reset) begin
        i_data_ctr  = '0;
        i_event_ctr = '0;
      end else if (o_enable) begin
        en_cnt++;
        i_data_ctr++;
        if (first_en == 0) first_en = t;
        if (en_cnt == v.inj0 || en_cnt == v.inj1 || en_cnt == v.inj2) i_event_ctr++;
        if (en_cnt == v.restart_at) i_start = 1'b1;
      end
      if (o_freeze && first_frz == 0) first_frz = t;
      if (o_done) done_t = t;
    end

    e = sb_q.pop_front();
    if (done_t == 0) begin
      check("done_timeout", o_done, 1);
    end else begin
      check("enable_cycles", en_cnt, e.exp_en);
      check("first_enable", first_en, (e.exp_en > 0) ? RC + 1 : 0);
      check("freeze_rise", first_frz, e.exp_frz);
      check("done_cycle", done_t, e.exp_frz + 1);
      check("res_data", o_res_data, e.exp_data);
      check("res_events", o_res_events, e.exp_events);
      check("pass", o_pass, e.exp_pass);
      check("done_freeze", o_freeze, 1);
      check("done_busy", o_busy, 0);
      check("done_state", o_state, 5);
`ifdef SEQ_EARLY_STOP_EN
      check("early", o_early, e.exp_early);
`endif
    end
    prev_data = e.exp_data;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    //            len  i0  i1  i2 rst stop ev pass en  early
    vecs[0] = '{100,  0,  0,  0,  0,  0,   0, 1'b1, 100, 1'b0};
    vecs[1] = '{100, 10, 20, 30,  0,  0,   3, 1'b0, 100, 1'b0};
    vecs[2] = '{  0,  0,  0,  0,  0,  0,   0, 1'b1,   0, 1'b0};
    vecs[3] = '{  1,  0,  0,  0,  0,  0,   0, 1'b1,   1, 1'b0};
    vecs[4] = '{  7,  3,  0,  0,  3,  0,   1, 1'b0,   7, 1'b0};
    nvec = 5;
`ifdef SEQ_EARLY_STOP_EN
    vecs[5] = '{1000, 20, 30, 0, 0,  2,   2, 1'b0,  30, 1'b1};
    nvec = 6;
`else
    vecs[5] = vecs[0];
`endif

    // Reset values while reset is asserted.
    @(posedge clk_dut); #1;
    check("rst_tb_reset", o_tb_reset, 1);
    check("rst_enable", o_enable, 0);
    check("rst_freeze", o_freeze, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_pass", o_pass, 0);
    check("rst_res_data", o_res_data, 0);
    check("rst_res_events", o_res_events, 0);
    check("rst_state", o_state, 0);
    reset = 1'b1;

    for (int i = 0; i < nvec; i++) run_vec(vecs[i]);

    // Abort in the 50th RUN cycle.
    @(posedge clk_dut); #1;
    i_start = 1'b1; i_run_len = 100;
    @(posedge clk_dut); #1;
    i_start = 1'b0;
    cnt = 0;
    for (int k = 0; k < 300 && cnt < 50; k++) begin
      @(posedge clk_dut); #1;
      if (o_enable) cnt++;
    end
    check("abort_reached_run", cnt, 50);
    i_abort = 1'b1;
    @(posedge clk_dut); #1;
    i_abort = 1'b0;
    check("abort_state", o_state, 0);
    check("abort_enable", o_enable, 0);
    check("abort_tb_reset", o_tb_reset, 1);
    check("abort_res_data", o_res_data, 0);
    check("abort_res_events", o_res_events, 0);
    check("abort_done", o_done, 0);
    prev_data = '0;
    run_vec('{10, 0, 0, 0, 0, 0, 0, 1'b1, 10, 1'b0});

    // Abort wins over start in the same cycle, and a held abort blocks start.
    i_abort = 1'b1; i_start = 1'b1; i_run_len = 5;
    @(posedge clk_dut); #1;
    i_start = 1'b0;
    check("abort_prio_state", o_state, 0);
    check("abort_prio_res", o_res_data, 0);
    check("abort_prio_done", o_done, 0);
    i_start = 1'b1;
    @(posedge clk_dut); #1;
    i_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_dut); #1;
      check("abort_hold_state", o_state, 0);
      check("abort_hold_tb_reset", o_tb_reset, 1);
    end
    i_abort = 1'b0;
    prev_data = '0;

    // Async reset mid-RUN drops enable without a clock edge.
    @(posedge clk_dut); #1;
    i_start = 1'b1; i_run_len = 20;
    @(posedge clk_dut); #1;
    i_start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk_dut); #1;
    end
    check("pre_async_enable", o_enable, 1);
    #2 reset = 1'b0;
    #1;
    check("async_enable", o_enable, 0);
    check("async_state", o_state, 0);
    check("async_tb_reset", o_tb_reset, 1);
    @(posedge clk_dut); #1;
    reset = 1'b1;
    prev_data = '0;
    run_vec('{3, 2, 0, 0, 0, 0, 1, 1'b0, 3, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
